// File: rtl/sign_restore_pkg.sv
// Shared constants, types and helpers for the sign_restore block.
package sign_restore_pkg;

    localparam int CNT_W     = 16;
    localparam int DEPTH_DEF = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy runs 0..DEPTH, so it needs one bit more than a pointer.
    typedef logic [ptr_w(DEPTH_DEF):0] fill_t;
    typedef logic [CNT_W-1:0]          cnt_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/sign_restore_fifo.sv
// sign_fifo: 1-bit wide synchronous FIFO holding the signs of in-flight samples.
module sign_fifo
    import sign_restore_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    din,
    output logic                    full,
    output logic                    empty,
    output logic                    head,
    output logic [ptr_w(DEPTH):0]   fill
);

    localparam int            PW       = ptr_w(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_fill;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    // NOTE: storage has no reset; stale bits are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    assign fill  = r_fill;
    assign full  = (r_fill == FULL_CNT);
    assign empty = (r_fill == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/sign_restore.sv
// sign_restore: re-applies stored signs to processed magnitudes (two's complement).
// Optional statistics counters enabled by defining SIGN_RESTORE_STAT_EN.
module sign_restore
    import sign_restore_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        sign_in,
    input  logic                        sign_we,
    input  logic [WIDTH-2:0]            mag_in,
    input  logic                        mag_we,
    input  logic                        clr_err,
    output logic signed [WIDTH-1:0]     out,
    output logic                        valid,
    output logic [ptr_w(DEPTH):0]       fill,
    output logic                        sign_full,
    output logic                        sign_empty,
    output logic                        ovf,
    output logic                        unf
`ifdef SIGN_RESTORE_STAT_EN
    ,
    output logic [CNT_W-1:0]            ovf_cnt,
    output logic [CNT_W-1:0]            unf_cnt
`endif
);

    logic             w_head;
    logic             w_pop;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [WIDTH-1:0] w_mag_ext;
    logic [WIDTH-1:0] w_restored;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic             r_ovf;
    logic             r_unf;

    sign_fifo #(.DEPTH(DEPTH)) u_sign_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (sign_we),
        .pop    (mag_we),
        .din    (sign_in),
        .full   (sign_full),
        .empty  (sign_empty),
        .head   (w_head),
        .fill   (fill)
    );

    assign w_pop     = mag_we & ~sign_empty;
    assign w_ovf_evt = sign_we & sign_full & ~mag_we;
    assign w_unf_evt = mag_we & sign_empty;
    assign w_mag_ext = {1'b0, mag_in};

    // NOTE: a default before the conditional keeps this purely combinational.
    always_comb begin
        w_restored = w_mag_ext;
        if (w_pop && w_head) w_restored = -w_mag_ext;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_valid <= mag_we;
            if (mag_we) r_out <= w_restored;
            // An error event in the clearing cycle keeps its flag set.
            if (w_ovf_evt)    r_ovf <= 1'b1;
            else if (clr_err) r_ovf <= 1'b0;
            if (w_unf_evt)    r_unf <= 1'b1;
            else if (clr_err) r_unf <= 1'b0;
        end
    end

    assign out   = $signed(r_out);
    assign valid = r_valid;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

`ifdef SIGN_RESTORE_STAT_EN
    cnt_t r_ovf_cnt;
    cnt_t r_unf_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else begin
            if (w_ovf_evt)    r_ovf_cnt <= clr_err ? cnt_t'(1) : sat_inc(r_ovf_cnt);
            else if (clr_err) r_ovf_cnt <= '0;
            if (w_unf_evt)    r_unf_cnt <= clr_err ? cnt_t'(1) : sat_inc(r_unf_cnt);
            else if (clr_err) r_unf_cnt <= '0;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
    assign unf_cnt = r_unf_cnt;
`endif

endmodule

// File: tb/tb_sign_restore.sv
// Self-checking bench for sign_restore (WIDTH=8, DEPTH=4), table-driven vectors.
module tb_sign_restore;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              sign_in;
    logic              sign_we;
    logic [WIDTH-2:0]  mag_in;
    logic              mag_we;
    logic              clr_err;
    logic signed [WIDTH-1:0] out;
    logic              valid;
    logic [2:0]        fill;
    logic              sign_full;
    logic              sign_empty;
    logic              ovf;
    logic              unf;
`ifdef SIGN_RESTORE_STAT_EN
    logic [15:0]       ovf_cnt;
    logic [15:0]       unf_cnt;
`endif

    sign_restore #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sign_in    (sign_in),
        .sign_we    (sign_we),
        .mag_in     (mag_in),
        .mag_we     (mag_we),
        .clr_err    (clr_err),
        .out        (out),
        .valid      (valid),
        .fill       (fill),
        .sign_full  (sign_full),
        .sign_empty (sign_empty),
        .ovf        (ovf),
        .unf        (unf)
`ifdef SIGN_RESTORE_STAT_EN
        ,
        .ovf_cnt    (ovf_cnt),
        .unf_cnt    (unf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit sw; bit si; bit mw; int mag; bit clr;
        int eo; bit ev; int ef; bit eov; bit eun; int eoc; int euc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit sw, bit si, bit mw, int mag, bit clr,
                                int eo, bit ev, int ef, bit eov, bit eun, int eoc, int euc);
        vec_t v;
        v.sw = sw; v.si = si; v.mw = mw; v.mag = mag; v.clr = clr;
        v.eo = eo; v.ev = ev; v.ef = ef; v.eov = eov; v.eun = eun; v.eoc = eoc; v.euc = euc;
        return v;
    endfunction

    task automatic idle_inputs();
        sign_we = 1'b0; sign_in = 1'b0; mag_we = 1'b0; mag_in = '0; clr_err = 1'b0;
    endtask

    task automatic check_state(input string tag, input int eo, input bit ev, input int ef,
                               input bit eov, input bit eun);
        check({tag, " out"},   {24'd0, out}, 32'(eo));
        check({tag, " valid"}, 32'(valid), 32'(ev));
        check({tag, " fill"},  32'(fill), 32'(ef));
        check({tag, " full"},  32'(sign_full), 32'(ef == DEPTH));
        check({tag, " empty"}, 32'(sign_empty), 32'(ef == 0));
        check({tag, " ovf"},   32'(ovf), 32'(eov));
        check({tag, " unf"},   32'(unf), 32'(eun));
    endtask

    initial begin
        //          sw si mw mag clr | out  v fill ovf unf ocnt ucnt
        // 1: signs 1,0,1 then magnitudes 5,7,127
        vecs.push_back(mk(1,1,0,  0,0, 8'h00,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,0,  0,0, 8'h00,0,2,0,0,0,0));
        vecs.push_back(mk(1,1,0,  0,0, 8'h00,0,3,0,0,0,0));
        vecs.push_back(mk(0,0,1,  5,0, 8'hFB,1,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,  7,0, 8'h07,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,127,0, 8'h81,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,  0,0, 8'h81,0,0,0,0,0,0));
        // 5: negative zero and most-negative magnitude
        vecs.push_back(mk(1,1,0,  0,0, 8'h81,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,  0,0, 8'h00,1,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,  0,0, 8'h00,0,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,127,0, 8'h81,1,0,0,0,0,0));
        // 2: overfill, drop, drain, clear
        vecs.push_back(mk(1,1,0,  0,0, 8'h81,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,  0,0, 8'h81,0,2,0,0,0,0));
        vecs.push_back(mk(1,0,0,  0,0, 8'h81,0,3,0,0,0,0));
        vecs.push_back(mk(1,0,0,  0,0, 8'h81,0,4,0,0,0,0));
        vecs.push_back(mk(1,1,0,  0,0, 8'h81,0,4,1,0,1,0));
        vecs.push_back(mk(0,0,1,  1,0, 8'hFF,1,3,1,0,1,0));
        vecs.push_back(mk(0,0,1,  1,0, 8'hFF,1,2,1,0,1,0));
        vecs.push_back(mk(0,0,1,  1,0, 8'h01,1,1,1,0,1,0));
        vecs.push_back(mk(0,0,1,  1,0, 8'h01,1,0,1,0,1,0));
        vecs.push_back(mk(0,0,0,  0,1, 8'h01,0,0,0,0,0,0));
        // 3: underflow and clear
        vecs.push_back(mk(0,0,1,  3,0, 8'h03,1,0,0,1,0,1));
        vecs.push_back(mk(0,0,0,  0,1, 8'h03,0,0,0,0,0,0));
        // 4: push+pop when full
        vecs.push_back(mk(1,0,0,  0,0, 8'h03,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,0,  0,0, 8'h03,0,2,0,0,0,0));
        vecs.push_back(mk(1,1,0,  0,0, 8'h03,0,3,0,0,0,0));
        vecs.push_back(mk(1,1,0,  0,0, 8'h03,0,4,0,0,0,0));
        vecs.push_back(mk(1,1,1,  9,0, 8'h09,1,4,0,0,0,0));
        vecs.push_back(mk(0,0,1,  2,0, 8'hFE,1,3,0,0,0,0));
        vecs.push_back(mk(0,0,1,  2,0, 8'hFE,1,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,  2,0, 8'hFE,1,1,0,0,0,0));
        vecs.push_back(mk(0,0,1,  2,0, 8'hFE,1,0,0,0,0,0));
        // Error event wins over clr_err in the same cycle
        vecs.push_back(mk(0,0,1,  4,1, 8'h04,1,0,0,1,0,1));
        vecs.push_back(mk(0,0,0,  0,1, 8'h04,0,0,0,0,0,0));
        // Push+pop when empty: no bypass, sign still stored
        vecs.push_back(mk(1,1,1,  6,0, 8'h06,1,1,0,1,0,1));
        vecs.push_back(mk(0,0,1,  6,0, 8'hFA,1,0,0,1,0,1));
        vecs.push_back(mk(0,0,0,  0,1, 8'hFA,0,0,0,0,0,0));

        idle_inputs();
        resetn = 1'b0;
        #12;
        check_state("reset", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            sign_we = vecs[i].sw;  sign_in = vecs[i].si;
            mag_we  = vecs[i].mw;  mag_in  = 7'(vecs[i].mag);
            clr_err = vecs[i].clr;
            @(posedge clk);
            #1;
            check_state($sformatf("v%0d", i), vecs[i].eo, vecs[i].ev, vecs[i].ef,
                        vecs[i].eov, vecs[i].eun);
`ifdef SIGN_RESTORE_STAT_EN
            check($sformatf("v%0d ovf_cnt", i), 32'(ovf_cnt), 32'(vecs[i].eoc));
            check($sformatf("v%0d unf_cnt", i), 32'(unf_cnt), 32'(vecs[i].euc));
`endif
        end

        // 6: reset mid-stream flushes stored signs
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            idle_inputs();
            sign_we = 1'b1; sign_in = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        mag_we = 1'b1; mag_in = 7'd1;
        @(posedge clk);
        #1;
        check_state("pre_rst", 8'hFF, 1, 3, 0, 0);
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        #2;
        check_state("mid_rst", 8'h00, 0, 0, 0, 0);
        #4;
        resetn = 1'b1;
        @(negedge clk);
        mag_we = 1'b1; mag_in = 7'd2;
        @(posedge clk);
        #1;
        check_state("post_rst", 8'h02, 1, 0, 0, 1);
`ifdef SIGN_RESTORE_STAT_EN
        check("post_rst ovf_cnt", 32'(ovf_cnt), 32'd0);
        check("post_rst unf_cnt", 32'(unf_cnt), 32'd1);
`endif
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("post_rst valid drop", 32'(valid), 32'd0);
        check("post_rst out hold", {24'd0, out}, 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
